mdu_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_arith.sv | 58 +++++
 rtl/mdu_unit.sv | 112 +++++++++++
 tb/tb_mdu_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state encoding.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_long_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide (signed/unsigned) built on a single
// unsigned magnitude datapath with sign fix-up.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next,
  output logic        div_by_zero
);

  logic        is_signed;
  logic        is_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [63:0] prod_mag;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_signed   = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_div      = (op == MDU_DIV) || (op == MDU_DIVU);
  assign a_neg       = is_signed & a[31];
  assign b_neg       = is_signed & b[31];
  assign a_mag       = a_neg ? -a : a;
  assign b_mag       = b_neg ? -b : b;
  assign div_by_zero = is_div && (b == 32'd0);

  // A zero divisor is replaced by 1 so the divider never sees 0; the result
  // is discarded by the caller anyway.
  assign divisor  = (b == 32'd0) ? 32'd1 : b_mag;
  assign q_mag    = a_mag / divisor;
  assign r_mag    = a_mag % divisor;
  assign prod_mag = {32'd0, a_mag} * {32'd0, b_mag};

  // 0x80000000 / -1 falls out naturally: |q| = 0x80000000, negated wraps to itself.
  assign prod = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
  assign quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem  = a_neg ? -r_mag : r_mag;

  always_comb begin
    if (is_div) begin
      hi_next = rem;
      lo_next = quot;
    end else begin
      hi_next = prod[63:32];
      lo_next = prod[31:0];
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV with shadow result,
// MTHI/MTLO, and the architectural HI/LO registers.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT,
  parameter int DIV_LAT  = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_op_e     op_e;
  mdu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_next, lo_next;
  logic        div_by_zero;
  logic        accept;

  assign op_e = mdu_op_e'(op);

  mdu_arith u_arith (
    .op          (op_e),
    .a           (a),
    .b           (b),
    .hi_next     (hi_next),
    .lo_next     (lo_next),
    .div_by_zero (div_by_zero)
  );

  // busy is the registered state, so acceptance never depends on a same-cycle raise.
  assign accept = start && !cancel && (state_q == MDU_IDLE)
                  && (op_e != MDU_NONE) && (op_e != MDU_RSVD);

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          if (is_long_op(op_e)) begin
            state_d  = MDU_BUSY;
            cnt_d    = (op_e == MDU_MULT || op_e == MDU_MULTU) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
            shadow_d = {hi_next, lo_next};
            dbz_d    = div_by_zero;
          end else if (op_e == MDU_MTHI) begin
            hi_d = a;
          end else begin
            lo_d = a;
          end
        end
      end
      MDU_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
          if (!dbz_q) begin
            hi_d = shadow_q[63:32];
            lo_d = shadow_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == MDU_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed cases from the test plan plus
// randomized op streams checked against an arithmetic reference model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  op;
  logic        start;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .start  (start),
    .cancel (cancel),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int tests;
  int fails;

  // Reference state: architectural HI/LO, cycles left on the running op, and its result.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;
  logic [63:0] m_res;
  logic        m_dbz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of a long op computed with plain 64-bit arithmetic.
  function automatic void ref_long(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [63:0] res, output logic dbz);
    longint          sq, sr;
    longint unsigned uq, ur;
    res = '0;
    dbz = 1'b0;
    case (o)
      3'd1: res = 64'(longint'($signed(x)) * longint'($signed(y)));
      3'd2: res = 64'(x) * 64'(y);
      3'd3: begin
        if (y == 0) dbz = 1'b1;
        else begin
          sq  = longint'($signed(x)) / longint'($signed(y));
          sr  = longint'($signed(x)) % longint'($signed(y));
          res = {sr[31:0], sq[31:0]};
        end
      end
      3'd4: begin
        if (y == 0) dbz = 1'b1;
        else begin
          uq  = 64'(x) / 64'(y);
          ur  = 64'(x) % 64'(y);
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = '0;
    endcase
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic [2:0] o, input logic s, input logic c,
                            input logic [31:0] x, input logic [31:0] y);
    logic        was_busy;
    logic        acc;
    logic [63:0] r;
    logic        z;
    exp_t        e;
    was_busy = (m_left > 0);
    acc = s && !c && !was_busy && (o != 3'd0) && (o != 3'd7);
    if (was_busy) begin
      m_left--;
      if (m_left == 0 && !m_dbz) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end
    if (acc) begin
      if (o >= 3'd1 && o <= 3'd4) begin
        ref_long(o, x, y, r, z);
        m_res  = r;
        m_dbz  = z;
        m_left = (o <= 3'd2) ? MULT_LAT : DIV_LAT;
        e.hi   = z ? m_hi : r[63:32];
        e.lo   = z ? m_lo : r[31:0];
        e.lat  = m_left;
        sb.push_back(e);
      end else if (o == 3'd5) begin
        m_hi = x;
      end else begin
        m_lo = x;
      end
    end
  endtask

  task automatic step(input logic [2:0] o, input logic s, input logic c,
                      input logic [31:0] x, input logic [31:0] y);
    op = o; start = s; cancel = c; a = x; b = y;
    @(posedge clk);
    model_edge(o, s, c, x, y);
    @(negedge clk);
    check("busy", 64'(busy), 64'(m_left > 0));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic idle(input int n);
    repeat (n) step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic mid_reset();
    op = 3'd0; start = 1'b0; cancel = 1'b0;
    @(posedge clk);
    model_edge(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0; m_left = 0; m_dbz = 1'b0;
    sb.delete();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: each busy fall is a commit; pop the oldest expectation and compare.
  initial begin : monitor
    bit   prev;
    int   run;
    exp_t e;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        run  = 0;
      end else begin
        if (busy) run++;
        else if (prev) begin
          if (sb.size() == 0) check("unexpected_commit", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            check("commit_hi", 64'(hi), 64'(e.hi));
            check("commit_lo", 64'(lo), 64'(e.lo));
            check("busy_cycles", 64'(run), 64'(e.lat));
          end
          run = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin : stim
    tests = 0; fails = 0;
    m_hi = '0; m_lo = '0; m_left = 0; m_res = '0; m_dbz = 1'b0;
    reset = 1'b1; op = 3'd0; start = 1'b0; cancel = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    #1 reset = 1'b0;

    // Mid-cycle reset after loading nonzero HI/LO.
    step(MDU_MTHI, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
    step(MDU_MTLO, 1'b1, 1'b0, 32'hCAFE_F00D, 32'd0);
    mid_reset();

    // MULT / MULTU of -2 (or 0xFFFFFFFE) by 3.
    step(MDU_MULT, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    idle(MULT_LAT);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);
    step(MDU_MULTU, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    idle(MULT_LAT);
    check("multu_hi", 64'(hi), 64'h0000_0002);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFA);

    // DIV -7/2, then DIVU by zero leaves preloaded HI/LO.
    step(MDU_DIV, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    idle(DIV_LAT);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    step(MDU_MTHI, 1'b1, 1'b0, 32'h11, 32'd0);
    step(MDU_MTLO, 1'b1, 1'b0, 32'h22, 32'd0);
    step(MDU_DIVU, 1'b1, 1'b0, 32'd7, 32'd0);
    idle(DIV_LAT);
    check("divu0_hi", 64'(hi), 64'h11);
    check("divu0_lo", 64'(lo), 64'h22);

    // Overflow case 0x80000000 / -1.
    step(MDU_DIV, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DIV_LAT);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'h0);

    // Back-to-back: DIV held while MULT is busy; accepted once busy is low.
    step(MDU_MULT, 1'b1, 1'b0, 32'd6, 32'd7);
    repeat (MULT_LAT + 1) step(MDU_DIV, 1'b1, 1'b0, 32'd100, 32'd7);
    idle(DIV_LAT);
    check("b2b_lo", 64'(lo), 64'd14);
    check("b2b_hi", 64'(hi), 64'd2);

    // Cancel suppresses MTHI; cancel during busy MULT is ignored.
    step(MDU_MTHI, 1'b1, 1'b1, 32'h1234, 32'd0);
    check("cancel_mthi", 64'(hi), 64'd2);
    step(MDU_MULTU, 1'b1, 1'b0, 32'h1_0000, 32'h1_0000);
    repeat (MULT_LAT) step(MDU_NONE, 1'b0, 1'b1, 32'd0, 32'd0);
    check("cancel_busy_hi", 64'(hi), 64'd1);
    check("cancel_busy_lo", 64'(lo), 64'd0);

    // Reset during a DIV: no later commit.
    step(MDU_DIV, 1'b1, 1'b0, 32'd99, 32'd3);
    idle(1);
    mid_reset();
    idle(DIV_LAT + 2);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);

    // Randomized stream, including starts while busy and cancels.
    for (int i = 0; i < 300; i++) begin
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           rand_operand(), rand_operand());
    end
    idle(DIV_LAT + 2);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
